// File: rtl/pipe_pkg.sv
// Shared constants for handshaked pipeline-stage registers.
package pipe_pkg;
    localparam logic [1:0] OCC_EMPTY  = 2'd0;
    localparam logic [1:0] OCC_ONE    = 2'd1;
    localparam logic [1:0] OCC_TWO    = 2'd2;
    localparam int         DATA_W_DEF = 48;
    localparam int         CTRL_W_DEF = 6;
    localparam int         STALL_W    = 16;
endpackage

// File: rtl/pipe_stage_hs_sat_counter.sv
// Saturating up-counter with synchronous clear, shared by performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/pipe_stage_hs.sv
// Reusable pipeline-stage register: valid/ready handshake, optional skid entry,
// synchronous flush, control bits zeroed whenever the stage is empty.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter bit SKID   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [1:0]         occupancy,
    output logic [STALL_W-1:0] stall_cnt
);
    logic [1:0]        occ;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              accept;
    logic              emit;

    assign out_valid = (occ != OCC_EMPTY);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    generate
        if (SKID) begin : g_skid
            logic skid_load;

            // Ready depends only on held state, breaking the out_ready->in_ready path.
            assign in_ready  = !rst && (occ != OCC_TWO);
            assign skid_load = (occ == OCC_ONE) && accept && !emit;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    skid_ctrl <= '0;
                end else if (skid_load) begin
                    skid_ctrl <= in_ctrl;
                end
            end

            always_ff @(posedge clk) begin
                if (skid_load) begin
                    skid_data <= in_data;
                end
            end
        end else begin : g_no_skid
            assign in_ready  = !rst && (!out_valid || out_ready);
            assign skid_data = '0;
            assign skid_ctrl = '0;
        end
    endgenerate

    // Main register: out_ctrl is cleared on every path into EMPTY.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ       <= OCC_EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
        end else if (flush) begin
            occ       <= OCC_EMPTY;
            main_ctrl <= '0;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (accept) begin
                        occ       <= OCC_ONE;
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end
                end
                OCC_ONE: begin
                    if (accept && emit) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end else if (accept) begin
                        occ <= OCC_TWO;
                    end else if (emit) begin
                        occ       <= OCC_EMPTY;
                        main_ctrl <= '0;
                    end
                end
                OCC_TWO: begin
                    if (emit) begin
                        occ       <= OCC_ONE;
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                    end
                end
                default: begin
                    occ       <= OCC_EMPTY;
                    main_ctrl <= '0;
                end
            endcase
        end
    end

    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign occupancy = occ;

    sat_counter #(
        .W(STALL_W)
    ) u_stall (
        .clk  (clk),
        .clear(rst),
        .inc  (out_valid && !out_ready),
        .count(stall_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: SKID=1 and SKID=0 instances share stimulus, each
// tracked by a queue-based reference model.
module tb_pipe_stage_hs;
    localparam int DW = 48;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst, in_valid, flush, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [DW-1:0] out_data1, out_data0;
    logic [CW-1:0] out_ctrl1, out_ctrl0;
    logic [1:0]    occ1, occ0;
    logic [15:0]   stall1, stall0;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t          q1[$];
    ent_t          q0[$];
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last0 = '0;
    int            st1 = 0;
    int            st0 = 0;

    always #5 clk = ~clk;

    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_ctrl(out_ctrl1), .occupancy(occ1), .stall_cnt(stall1)
    );

    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_ctrl(out_ctrl0), .occupancy(occ0), .stall_cnt(stall0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [DW-1:0] d1, d0;
        logic [CW-1:0] c1, c0;
        d1 = last1; c1 = '0;
        d0 = last0; c0 = '0;
        if (q1.size() > 0) begin d1 = q1[0].d; c1 = q1[0].c; end
        if (q0.size() > 0) begin d0 = q0[0].d; c0 = q0[0].c; end
        chk("s1_valid", 64'(out_valid1), 64'(q1.size() > 0));
        chk("s1_data", 64'(out_data1), 64'(d1));
        chk("s1_ctrl", 64'(out_ctrl1), 64'(c1));
        chk("s1_occ", 64'(occ1), 64'(q1.size()));
        chk("s1_stall", 64'(stall1), 64'(st1));
        chk("s1_ready", 64'(in_ready1), 64'(!rst && q1.size() < 2));
        chk("s0_valid", 64'(out_valid0), 64'(q0.size() > 0));
        chk("s0_data", 64'(out_data0), 64'(d0));
        chk("s0_ctrl", 64'(out_ctrl0), 64'(c0));
        chk("s0_occ", 64'(occ0), 64'(q0.size()));
        chk("s0_stall", 64'(stall0), 64'(st0));
        chk("s0_ready", 64'(in_ready0), 64'(!rst && (q0.size() == 0 || out_ready)));
    endtask

    // One clock: optionally check, then advance model across the rising edge.
    task automatic cycle(input bit do_chk);
        bit   r1, r0, a1, a0, e1, e0;
        ent_t e;
        if (do_chk) begin
            #1;
            check_model();
        end
        r1 = !rst && q1.size() < 2;
        r0 = !rst && (q0.size() == 0 || out_ready);
        a1 = in_valid && r1;
        a0 = in_valid && r0;
        e1 = q1.size() > 0 && out_ready;
        e0 = q0.size() > 0 && out_ready;
        e.d = in_data;
        e.c = in_ctrl;
        @(posedge clk);
        if (rst) begin
            q1.delete(); q0.delete();
            last1 = '0; last0 = '0;
            st1 = 0; st0 = 0;
        end else begin
            if (q1.size() > 0 && !out_ready && st1 < 65535) st1++;
            if (q0.size() > 0 && !out_ready && st0 < 65535) st0++;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (e1) void'(q1.pop_front());
                if (a1) q1.push_back(e);
                if (e0) void'(q0.pop_front());
                if (a0) q0.push_back(e);
            end
            if (q1.size() > 0) last1 = q1[0].d;
            if (q0.size() > 0) last0 = q0[0].d;
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset held two cycles with in_valid asserted.
        rst = 1'b1; in_valid = 1'b1; in_data = 48'h55; in_ctrl = 6'h3F;
        flush = 1'b0; out_ready = 1'b0;
        cycle(0);
        cycle(1);
        chk("rst_valid", 64'(out_valid1), 64'd0);
        chk("rst_ctrl", 64'(out_ctrl1), 64'd0);
        chk("rst_occ", 64'(occ1), 64'd0);
        chk("rst_ready1", 64'(in_ready1), 64'd0);
        chk("rst_ready0", 64'(in_ready0), 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_rst_ready1", 64'(in_ready1), 64'd1);
        chk("post_rst_ready0", 64'(in_ready0), 64'd1);
        cycle(1);

        // Streaming with out_ready high.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DW'(i); in_ctrl = CW'(i);
            cycle(1);
            chk("stream_valid", 64'(out_valid1), 64'd1);
            chk("stream_data", 64'(out_data1), 64'(i));
            chk("stream_data0", 64'(out_data0), 64'(i));
        end
        in_valid = 1'b0;
        cycle(1);
        chk("stream_stall", 64'(stall1), 64'd0);

        // Backpressure: A to main, B to skid, C held upstream.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 48'hA; in_ctrl = 6'h01;
        cycle(1);
        in_data = 48'hB; in_ctrl = 6'h02;
        cycle(1);
        in_data = 48'hC; in_ctrl = 6'h03;
        #1;
        chk("bp_occ", 64'(occ1), 64'd2);
        chk("bp_ready", 64'(in_ready1), 64'd0);
        chk("bp_main", 64'(out_data1), 64'hA);
        for (int i = 0; i < 3; i++) cycle(1);
        out_ready = 1'b1;
        cycle(1);
        chk("bp_order_b", 64'(out_data1), 64'hB);
        cycle(1);
        chk("bp_order_c", 64'(out_data1), 64'hC);
        in_valid = 1'b0;
        cycle(1);
        chk("bp_stall", 64'(stall1), 64'd4);

        // Flush with two held entries and a same-cycle offer of 0xD.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 48'h11; in_ctrl = 6'h3F;
        cycle(1);
        in_data = 48'h22;
        cycle(1);
        chk("fl_occ_pre", 64'(occ1), 64'd2);
        flush = 1'b1; in_data = 48'hD;
        cycle(1);
        chk("fl_valid", 64'(out_valid1), 64'd0);
        chk("fl_ctrl", 64'(out_ctrl1), 64'd0);
        chk("fl_occ", 64'(occ1), 64'd0);
        chk("fl_data_kept", 64'(out_data1), 64'h11);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle(1);
            chk("fl_no_d", 64'(out_valid1), 64'd0);
        end

        // SKID=0: in_ready follows out_ready combinationally.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 48'hE; in_ctrl = 6'h05;
        cycle(1);
        in_data = 48'hF; in_ctrl = 6'h06;
        #1;
        chk("s0_hold_ready", 64'(in_ready0), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("s0_comb_ready", 64'(in_ready0), 64'd1);
        cycle(1);
        chk("s0_replace", 64'(out_data0), 64'hF);
        chk("s0_replace_occ", 64'(occ0), 64'd1);
        in_valid = 1'b0;
        cycle(1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = {16'($urandom), 32'($urandom)};
            in_ctrl   = CW'($urandom);
            flush     = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            cycle(1);
        end
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        cycle(1);
        rst = 1'b0;

        // Saturation of the stall counter.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 48'h77; in_ctrl = 6'h11;
        cycle(1);
        in_valid = 1'b0;
        for (int i = 0; i < 70000; i++) cycle(0);
        chk("sat_s1", 64'(stall1), 64'hFFFF);
        chk("sat_s0", 64'(stall0), 64'hFFFF);
        cycle(1);
        chk("sat_hold", 64'(stall1), 64'hFFFF);
        flush = 1'b1;
        cycle(1);
        flush = 1'b0;
        chk("sat_flush", 64'(stall1), 64'hFFFF);
        rst = 1'b1;
        cycle(1);
        chk("sat_rst", 64'(stall1), 64'd0);
        chk("sat_rst0", 64'(stall0), 64'd0);
        rst = 1'b0;
        cycle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised pipeline-stage register with valid/ready handshake, optional 2-entry skid buffer, synchronous flush and bubble-safe control fields. It generalises the fixed EX/MEM and MEM/WB latches of the pipelined core into one reusable block. Any stage boundary can now stall, drain or be squashed on a branch or exception without corrupting architectural side-effect bits. A saturating stall counter per instance supports performance debug.

## Interface
- DATA_W, 48: width of payload (instruction, PC+1, ALU result, read data, write-register index); never forced to zero.
- CTRL_W, 6: width of side-effect control bits (RegWrite, MemWrite, IN, OUT, MemtoReg); forced to 0 whenever the stage holds no valid entry.
- SKID, 1: 1 = two-entry skid buffer (in_ready is registered-state only); 0 = single register (in_ready = !out_valid || out_ready).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bits.
- flush  in  1  synchronous squash of all held entries.
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  registered payload.
- out_ctrl  out  CTRL_W  registered control bits, 0 when !out_valid.
- occupancy  out  2  entries held (0, 1, 2).
- stall_cnt  out  16  cycles with out_valid && !out_ready, saturating.

## Operation
- accept = in_valid && in_ready; emit = out_valid && out_ready.
- States: EMPTY (occ 0), ONE (main reg valid), TWO (main + skid valid; SKID=1 only).
- EMPTY: accept -> ONE, main <= in.
- ONE: accept && emit -> ONE, main <= in; accept && !emit -> TWO, skid <= in; emit && !accept -> EMPTY; neither -> hold.
- TWO: in_ready = 0; emit -> ONE, main <= skid; else hold.
- SKID=0: TWO unreachable; in_ready = !rst && (!out_valid || out_ready).
- SKID=1: in_ready = !rst && state != TWO; no combinational path from out_ready.
- Priority: rst > flush > normal transitions.
- flush: next state EMPTY, out_ctrl <= 0, skid ctrl <= 0; any same-cycle accept is discarded; out_data keeps its last value; stall_cnt not affected.
- out_ctrl tracks main-register ctrl while valid, and is 0 in EMPTY; skid ctrl is never exposed directly.
- stall_cnt: +1 per cycle with out_valid && !out_ready; holds at 16'hFFFF; cleared only by rst.

## Timing
- Reset values: out_valid 0, out_data 0, out_ctrl 0, occupancy 0, stall_cnt 0, in_ready 0 during rst, 1 on the first cycle after rst deasserts.
- Latency: accept at edge N -> out_valid, out_data, out_ctrl valid after edge N (visible in cycle N+1).
- Throughput: 1 entry/cycle sustained with out_ready held high, for both SKID values.
- All outputs registered except in_ready (combinational from state and rst; SKID=0 adds out_ready).
- Order preserved: skid entry is always emitted after the main entry.
- rst or flush mid-stall: entries are dropped in that cycle and the stage is empty next cycle; no partial emit.
- flush and emit in the same cycle: downstream sees the emit (handshake completes); the stage is still empty after the edge.

## Structure
- Shared package pipe_pkg: occupancy localparams OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_TWO=2'd2; default DATA_W/CTRL_W; stall counter width (16).
- One sub-module: sat_counter (parametrised width, inc, clear, saturate), reused by other performance counters.
- Skid register logic is generated out when SKID=0.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=0; cycle after release, in_ready=1.
- Streaming: SKID=1, out_ready=1, push data 1..8 back-to-back -> out_data 1..8 one cycle later, no gaps, stall_cnt=0.
- Backpressure: SKID=1, out_ready=0, push 0xA, 0xB, 0xC -> 0xA in main, 0xB in skid, occupancy=2, in_ready=0, 0xC held upstream; release -> A, B, C in order; stall_cnt equals stalled cycles.
- Flush: occupancy=2 with ctrl=6'h3F, pulse flush with in_valid=1 and data 0xD -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0xD never appears.
- SKID=0: out_ready=0 with entry held -> in_ready=0 in the same cycle; raise out_ready -> in_ready=1 combinationally, replacement accepted at that edge.
- Saturation: force 70000 stall cycles -> stall_cnt=16'hFFFF and holds; flush leaves it unchanged; rst clears it to 0.
